// File: rtl/asic_freq_counter.sv
// Frequency counter: gated and free-running edge counts of an asynchronous input,
// reported on parallel outputs, as a UART hex line and on a 9-digit multiplexed display.
module asic_freq_counter #(
  parameter int unsigned DEFAULT_DIV    = 87,
  parameter int unsigned DEFAULT_PERIOD = 10000000,
  parameter int unsigned MUX_CYCLES     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr,
  input  logic [31:0] value,
  input  logic        strobe,
  input  logic        samplee,
  output logic [31:0] o,
  output logic [31:0] oc,
  output logic        tx,
  output logic [8:0]  col_drvs,
  output logic [7:0]  seg_drvs
);

  localparam int MUX_W = (MUX_CYCLES > 1) ? $clog2(MUX_CYCLES) : 1;

  typedef enum logic [0:0] {UART_IDLE, UART_SEND} uart_state_t;

  logic [31:0] divider, period, digits;
  logic [3:0]  digit8;
  logic [8:0]  dp;
  logic        mode;
  logic [2:0]  sync_q;
  logic        edge_pulse, period_wr, new_result;
  logic [31:0] window, cnt;

  uart_state_t uart_state;
  logic [31:0] line_val, bit_cnt, bit_div;
  logic [3:0]  char_idx, bit_idx;
  logic [9:0]  frame;

  logic [MUX_W-1:0] mux_cnt;
  logic [3:0]  col, next_col, nibble;
  logic        blank;
  logic [7:0]  seg_next;

  function automatic logic [6:0] hex_seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Characters 0..7 are hex nibbles MSB first, then CR, LF.
  function automatic logic [7:0] line_char(input logic [31:0] val, input logic [3:0] idx);
    logic [3:0] nib;
    nib = 4'(val >> (5'd28 - {idx[2:0], 2'b00}));
    if (idx == 4'd8)      return 8'h0D;
    else if (idx == 4'd9) return 8'h0A;
    else if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else                  return 8'h37 + {4'h0, nib};
  endfunction

  assign period_wr  = strobe && (addr == 4'd1);
  assign edge_pulse = sync_q[1] & ~sync_q[2];

  // NOTE: every clocked block uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      divider <= 32'(DEFAULT_DIV);
      period  <= 32'(DEFAULT_PERIOD);
      mode    <= 1'b0;
      digits  <= '0;
      digit8  <= '0;
      dp      <= '0;
    end else if (strobe) begin
      case (addr)
        4'd0:    divider <= (value < 32'd4) ? 32'd4 : value;
        4'd1:    period  <= (value == 32'd0) ? 32'd1 : value;
        4'd2:    mode    <= value[0];
        4'd3:    digits  <= value;
        4'd4:    digit8  <= value[3:0];
        4'd5:    dp      <= value[8:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      oc         <= '0;
      o          <= '0;
      cnt        <= '0;
      window     <= '0;
      new_result <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], samplee};
      new_result <= 1'b0;
      oc         <= oc + {31'b0, edge_pulse};
      if (period_wr) begin
        window <= '0;
        cnt    <= '0;
      end else if (window == period - 32'd1) begin
        // An edge on the closing cycle still belongs to this window.
        o          <= cnt + {31'b0, edge_pulse};
        cnt        <= '0;
        window     <= '0;
        new_result <= 1'b1;
      end else begin
        cnt    <= cnt + {31'b0, edge_pulse};
        window <= window + 32'd1;
      end
    end
  end

  // frame = {stop, data[7:0], start}; shifted out LSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_state <= UART_IDLE;
      tx         <= 1'b1;
      line_val   <= '0;
      char_idx   <= '0;
      bit_idx    <= '0;
      bit_cnt    <= '0;
      bit_div    <= 32'(DEFAULT_DIV);
      frame      <= '1;
    end else begin
      case (uart_state)
        UART_IDLE: begin
          if (new_result) begin
            line_val   <= o;
            char_idx   <= '0;
            bit_idx    <= '0;
            bit_cnt    <= '0;
            bit_div    <= divider;
            frame      <= {1'b1, line_char(o, 4'd0), 1'b0};
            tx         <= 1'b0;
            uart_state <= UART_SEND;
          end
        end
        UART_SEND: begin
          if (bit_cnt == bit_div - 32'd1) begin
            bit_cnt <= '0;
            if (bit_idx == 4'd9) begin
              if (char_idx == 4'd9) begin
                tx         <= 1'b1;
                uart_state <= UART_IDLE;
              end else begin
                char_idx <= char_idx + 4'd1;
                bit_idx  <= '0;
                bit_div  <= divider;
                frame    <= {1'b1, line_char(line_val, char_idx + 4'd1), 1'b0};
                tx       <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              frame   <= {1'b1, frame[9:1]};
              tx      <= frame[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 32'd1;
          end
        end
        default: uart_state <= UART_IDLE;
      endcase
    end
  end

  // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
  always_comb begin
    next_col = (col == 4'd8) ? 4'd0 : col + 4'd1;
    nibble   = digit8;
    blank    = 1'b0;
    if (next_col == 4'd8) begin
      nibble = digit8;
      blank  = ~mode;
    end else if (mode) begin
      nibble = 4'(digits >> {next_col[2:0], 2'b00});
    end else begin
      nibble = 4'(o >> {next_col[2:0], 2'b00});
    end
    seg_next = {|(dp & (9'd1 << next_col)), blank ? 7'h00 : hex_seg(nibble)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_cnt  <= '0;
      col      <= '0;
      col_drvs <= 9'd1;
      seg_drvs <= 8'h3F;
    end else if (mux_cnt == MUX_W'(MUX_CYCLES - 1)) begin
      mux_cnt  <= '0;
      col      <= next_col;
      col_drvs <= 9'd1 << next_col;
      seg_drvs <= seg_next;
    end else begin
      mux_cnt <= mux_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_asic_freq_counter.sv
// Directed bench for asic_freq_counter; UART bytes are checked against a scoreboard queue.
module tb_asic_freq_counter;

  localparam int MUX = 1024;
  localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  addr;
  logic [31:0] value;
  logic        strobe;
  logic        samplee;
  logic [31:0] o, oc;
  logic        tx;
  logic [8:0]  col_drvs;
  logic [7:0]  seg_drvs;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   sq_en = 1'b0;
  bit   rx_enable = 1'b0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  asic_freq_counter #(
    .DEFAULT_DIV(87), .DEFAULT_PERIOD(10000000), .MUX_CYCLES(MUX)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .value(value), .strobe(strobe), .samplee(samplee),
    .o(o), .oc(oc), .tx(tx), .col_drvs(col_drvs), .seg_drvs(seg_drvs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: land on the falling edge, then drive the square wave if enabled.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (sq_en) samplee = ((cyc % 10) < 5);
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] v);
    addr = a; value = v; strobe = 1'b1;
    step();
    strobe = 1'b0;
  endtask

  task automatic pulse();
    samplee = 1'b1; step();
    samplee = 1'b0; step();
  endtask

  task automatic wait_col(input logic [8:0] target, input int budget);
    logic [8:0] prev;
    int n;
    n = 0;
    prev = col_drvs;
    step();
    while (!(col_drvs == target && prev != target) && n < budget) begin
      prev = col_drvs;
      step();
      n++;
    end
    check("col_transition_seen", col_drvs, target);
  endtask

  // UART receiver at 4 clocks per bit, sampling near each bit centre.
  initial begin : uart_rx
    logic [7:0] rx_byte;
    logic start_bit, stop_bit;
    forever begin
      @(negedge clk);
      if (rx_enable && tx === 1'b0) begin
        repeat (2) @(negedge clk);
        start_bit = tx;
        for (int k = 0; k < 8; k++) begin
          repeat (4) @(negedge clk);
          rx_byte[k] = tx;
        end
        repeat (4) @(negedge clk);
        stop_bit = tx;
        if (rx_enable) begin
          check("uart_start_bit", {31'b0, start_bit}, 32'd0);
          check("uart_stop_bit", {31'b0, stop_bit}, 32'd1);
          check("uart_byte_expected", {31'b0, exp_q.size() > 0}, 32'd1);
          if (exp_q.size() > 0) check("uart_byte", {24'b0, rx_byte}, {24'b0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string hex_line;
    logic [31:0] oc_a;
    int guard;

    rst = 1'b1; addr = '0; value = '0; strobe = 1'b0; samplee = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_o", o, 32'd0);
    check("reset_oc", oc, 32'd0);
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_col", {23'b0, col_drvs}, 32'h001);

    // Square wave with a 10-clock period, divider request 2 (stored as 4), gate 100.
    rx_enable = 1'b1;
    sq_en = 1'b1;
    repeat (20) step();
    write_reg(4'd0, 32'd2);
    hex_line = "0000000A";
    for (int i = 0; i < hex_line.len(); i++) exp_q.push_back(hex_line[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    write_reg(4'd1, 32'd100);
    repeat (99) step();
    check("o_before_first_boundary", o, 32'd0);
    step();
    check("o_window1", o, 32'd10);
    oc_a = oc;
    repeat (100) step();
    check("o_window2", o, 32'd10);
    check("oc_growth_per_100clk", oc - oc_a, 32'd10);
    repeat (100) step();
    check("o_window3", o, 32'd10);
    write_reg(4'd1, 32'd1_000_000);
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      step();
      guard++;
    end
    check("uart_line_complete", exp_q.size(), 32'd0);
    repeat (400) step();

    // Display, mode 0: o = 0xA on digit 0, digit 8 blank.
    wait_col(9'h001, 9 * MUX + 16);
    check("m0_col0_seg", {24'b0, seg_drvs}, 32'h77);
    repeat (8 * MUX) step();
    check("m0_col8", {23'b0, col_drvs}, 32'h100);
    check("m0_col8_seg", {24'b0, seg_drvs}, 32'h00);

    // Display, mode 1: digit n shows n with its decimal point lit.
    write_reg(4'd2, 32'd1);
    write_reg(4'd3, 32'h7654_3210);
    write_reg(4'd4, 32'd8);
    write_reg(4'd5, 32'h1FF);
    wait_col(9'h001, 9 * MUX + 16);
    check("m1_col0_seg", {24'b0, seg_drvs}, 32'hBF);
    for (int n = 1; n <= 9; n++) begin
      repeat (MUX - 1) step();
      check($sformatf("m1_col_hold%0d", n - 1), {23'b0, col_drvs}, 32'd1 << (n - 1));
      step();
      check($sformatf("m1_col_step%0d", n % 9), {23'b0, col_drvs}, 32'd1 << (n % 9));
      check($sformatf("m1_seg_col%0d", n % 9), {24'b0, seg_drvs}, {24'b0, 1'b1, SEG_TAB[n % 9]});
    end

    // A period write mid-window drops the partial count and restarts the window.
    sq_en = 1'b0; samplee = 1'b0; rx_enable = 1'b0;
    repeat (10) step();
    write_reg(4'd1, 32'd50);
    repeat (4) step();
    pulse(); pulse(); pulse();
    repeat (9) step();
    write_reg(4'd1, 32'd50);
    repeat (4) step();
    pulse(); pulse();
    repeat (23) step();
    check("o_old_boundary_skipped", o, 32'd10);
    repeat (18) step();
    check("o_restart_pre_boundary", o, 32'd10);
    step();
    check("o_restart_window", o, 32'd2);

    // Edges land at window cycles 20, 30, 51 (boundary) and 53.
    write_reg(4'd1, 32'd50);
    repeat (16) step();
    pulse();
    repeat (8) step();
    pulse();
    repeat (19) step();
    pulse();
    check("o_pre_boundary", o, 32'd2);
    samplee = 1'b1;
    step();
    check("o_boundary_edge_closing", o, 32'd3);
    samplee = 1'b0;
    step();
    repeat (48) step();
    check("o_next_window_hold", o, 32'd3);
    step();
    check("o_next_window", o, 32'd1);

    // Continuous counter wrap, with the 3-clock edge latency.
    force dut.oc = 32'hFFFF_FFFF;
    step();
    release dut.oc;
    step();
    check("oc_preload", oc, 32'hFFFF_FFFF);
    samplee = 1'b1; step();
    samplee = 1'b0; step();
    check("oc_latency_hold", oc, 32'hFFFF_FFFF);
    step();
    check("oc_wrap", oc, 32'd0);

    // Reset in the middle of a UART frame.
    sq_en = 1'b1;
    write_reg(4'd1, 32'd20);
    repeat (20) step();
    check("o_period20", o, 32'd2);
    guard = 0;
    while (tx !== 1'b0 && guard < 1000) begin
      step();
      guard++;
    end
    check("tx_in_frame", {31'b0, tx}, 32'd0);
    rst = 1'b1;
    step();
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_o", o, 32'd0);
    check("rst_oc", oc, 32'd0);
    check("rst_col", {23'b0, col_drvs}, 32'h001);
    rst = 1'b0; sq_en = 1'b0; samplee = 1'b0;
    repeat (5) step();
    check("tx_idle_after_rst", {31'b0, tx}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/asic_freq_counter.md
Name: asic_freq_counter

Overview:
Frequency counter for the multi-project harness. Counts rising edges of an external signal over a programmable gate period, and also keeps a free-running edge count. Each result is reported on the Wishbone read outputs, as an ASCII hex line on a UART, and on a multiplexed 9-digit 7-segment display. Configuration arrives through a simple strobed register-write port decoded by the harness.

Parameters:
DEFAULT_DIV, 87, reset value of UART clock divider (sys clocks per bit)
DEFAULT_PERIOD, 10000000, reset value of gate period in sys clocks
MUX_CYCLES, 1024, sys clocks each display column stays active

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
addr  input  4  register index (byte address bits 5:2)
value  input  32  write data
strobe  input  1  single-cycle write enable (harness asserts only for full 32-bit writes)
samplee  input  1  signal under test, asynchronous
o  output  32  edge count latched at end of last gate period
oc  output  32  continuous edge count, never cleared except by rst
tx  output  1  UART output, 8N1, idle high
col_drvs  output  9  one-hot column drivers, active-high, bit n = digit n
seg_drvs  output  8  segment drivers, active-high, {dp,g,f,e,d,c,b,a}

Behaviour:
- Write registers (on strobe, by addr):
  - 0: UART divider. Values below 4 are stored as 4.
  - 1: gate period. 0 is stored as 1. A write also clears the window counter and the partial count.
  - 2: display mode, bit0 (0 = measured freq, 1 = wishbone value).
  - 3: digits 7..0, 4 bits each.
  - 4: digit8, bits 3:0.
  - 5: decimal points 8..0, bits 8:0.
  - addr ≥ 6: ignored.
- Reset values: divider=DEFAULT_DIV, period=DEFAULT_PERIOD, mode=0, digit regs=0, dp=0, o=0, oc=0, tx=1, col_drvs=000000001, UART idle.
- Input path: samplee passes through a 2-FF synchronizer. A rising edge is detected from the 2nd vs 3rd stage. Edge pulse latency is 3 clk.
- Continuous counter: oc increments on every edge pulse and wraps 0xFFFFFFFF→0.
- Periodic counter:
  - Window counter runs 0..P-1.
  - On the cycle with window = P-1: o <= cnt + edge, cnt <= 0, window <= 0, and a "new result" pulse is raised.
  - Otherwise cnt <= cnt + edge.
  - An edge on the boundary cycle belongs to the closing window.
  - cnt wraps on overflow.
- UART:
  - On each "new result" pulse while idle, transmits o as 8 uppercase ASCII hex chars, MSB nibble first, then 0x0D 0x0A.
  - Each byte is framed as start bit, 8 data bits LSB first, stop bit.
  - Each bit lasts exactly divider clocks. The divider is sampled at the start of each byte.
  - A result arriving while a line is in progress is dropped (no queueing).
- Display:
  - Column index advances every MUX_CYCLES clocks, 0..8, then wraps to 0.
  - Exactly one col_drvs bit is high at all times.
  - Mode 0: digits 7..0 show o in hex; digit8 is blank (segments a–g off).
  - Mode 1: digits 0..7 come from reg 3 nibbles; digit8 comes from reg 4.
  - Hex-to-segment encoding is the standard one: 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F A=0x77 b=0x7C C=0x39 d=0x5E E=0x79 F=0x71.
  - seg_drvs[7] = dp bit of the active column, in both modes.
  - Outputs are registered and change on the same edge as the column advance.
- rst mid-operation aborts any UART frame (tx=1 next cycle) and clears all counters.

Test Plan:
- Reset, write period=100, drive samplee as a 10-clk-period square wave -> after the first full window, o=10 on every subsequent window; oc grows by 10 per 100 clk.
- Write addr0=2 -> divider reads back as 4 in behaviour. After a result, tx bit width = 4 clk; line decodes to "0000000A\r\n" for o=0xA.
- Write mode=1, reg3=0x76543210, reg4=8, reg5=0x1FF -> column n shows digit n's pattern with dp set (e.g. column 0 seg=0xBF, column 8 seg=0xFF), one-hot columns stepping every MUX_CYCLES.
- Edge on exactly the boundary cycle -> counted in closing window's o, not the next.
- Preload oc to near wrap via long stimulus (or force) -> 0xFFFFFFFF + edge = 0; a period write mid-window restarts the window with cnt=0.
- Assert rst during UART transmission -> tx=1 next clk; o=oc=0; col_drvs=000000001.
